// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, in-order fetch requests, response FIFO to decode
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect -> sticky misalign_err, ERR state)
// Ports: clk, rst_n (async active-low) | imem_req_valid/ready/addr request | imem_rsp_valid/data response
//        redirect_valid/redirect_pc from execute | id_valid/ready/instr/pc/opcode to decode | misalign_err
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [6:0]        id_opcode,
    output logic              misalign_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_kill_cnt;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [31:0]       r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];

    logic              w_run;
    logic              w_req_fire;
    logic              w_push;
    logic              w_pop;
    logic [CW:0]       w_credit_used;
    logic [CW-1:0]     w_out_nxt;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_misalign;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_redirect_pc = redirect_pc;
    assign w_misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err  = r_misalign;
`else
    // Low address bits are ignored: every redirect lands on a word boundary.
    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    assign w_misalign    = 1'b0;
    assign misalign_err  = 1'b0;
`endif

    assign w_run = (r_state == S_RUN);

    // Credit: in-flight requests plus buffered responses never exceed the FIFO depth,
    // so every accepted response always has a free slot.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid = w_run && !redirect_valid && (w_credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = (r_state == S_IDLE) ? '0 : r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign id_valid  = (r_count != '0);
    assign id_instr  = r_fifo_instr[r_rd_ptr];
    assign id_pc     = r_fifo_pc[r_rd_ptr];
    assign id_opcode = r_fifo_instr[r_rd_ptr][6:0];
    assign w_pop     = id_valid && id_ready;

    // Responses in a redirect cycle, or while stale requests remain, never reach the FIFO.
    assign w_push = imem_rsp_valid && w_run && !redirect_valid && (r_kill_cnt == '0);

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_req_fire)     w_out_nxt = w_out_nxt + CW'(1);
        if (imem_rsp_valid) w_out_nxt = w_out_nxt - CW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_misalign ? state_t'(2) : S_RUN;
            S_RUN:   if (w_misalign) w_state_nxt = state_t'(2);
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_outstanding <= w_out_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_kill_cnt <= w_out_nxt;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                if (imem_rsp_valid && (r_kill_cnt != '0)) r_kill_cnt <= r_kill_cnt - CW'(1);
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
                    r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
                    r_wr_ptr               <= r_wr_ptr + PW'(1);
                    r_rsp_pc               <= r_rsp_pc + ADDR_W'(4);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_misalign) begin
            r_misalign <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            assert (r_count < CW'(FIFO_DEPTH));
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic        misalign_err;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_rsp    = 0;
    int          n_del    = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem_q [$];
    logic [31:0] exp_addr;
    logic        mem_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called early in cycle T; returns early in cycle T+1 with the new stream expected.
    task automatic do_redirect(input logic [31:0] pc, input logic [31:0] eff);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        check("no_req_in_redirect_cycle", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        push_run(eff, 128);
        exp_addr = eff;
    endtask

    // Memory request side and decode-side scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            mem_q.push_back(imem_req_addr);
            n_acc++;
        end
        if (rst_n && id_valid && id_ready) begin
            logic [31:0] e;
            logic [31:0] ei;
            n_del++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ei = ~e;
                check("id_pc", id_pc, e);
                check("id_instr", id_instr, ei);
                check("id_opcode", {25'd0, id_opcode}, {25'd0, ei[6:0]});
            end
        end
    end

    // Memory response side: in order, one per cycle, at least one cycle after accept.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (!mem_hold && mem_q.size() != 0) begin
                imem_rsp_data  = ~mem_q.pop_front();
                imem_rsp_valid = 1'b1;
                n_rsp++;
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        int          d0;
        int          a0;
        logic        found;
        logic [31:0] held_addr;

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_hold       = 1'b0;
        exp_addr       = 32'h0;
        push_run(32'h0, 128);

        // Reset values
        cyc(3);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(imem_req_valid), 32'd0);

        // Streaming from RESET_PC with 1-cycle memory
        d0 = n_del;
        cyc(41);
        check("throughput_ge_half", 32'((n_del - d0) >= 20), 32'd1);

        // Decode stall: credit cap and issue stall, then in-order drain
        id_ready = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #2;
            check("inflight_le_depth", 32'((n_acc - n_del) <= 2), 32'd1);
        end
        check("stall_inflight_full", 32'(n_acc - n_del), 32'd2);
        check("stall_req_dropped", 32'(imem_req_valid), 32'd0);
        check("stall_id_valid", 32'(id_valid), 32'd1);
        id_ready = 1'b1;
        d0 = n_del;
        cyc(20);
        check("drain_delivers", 32'((n_del - d0) >= 6), 32'd1);

        // Redirect with two requests outstanding
        mem_hold = 1'b1;
        cyc(6);
        #1;
        check("two_outstanding", 32'(n_acc - n_rsp), 32'd2);
        do_redirect(32'h100, 32'h100);
        mem_hold = 1'b0;
        @(negedge clk);
        check("id_valid_low_after_redirect", 32'(id_valid), 32'd0);
        d0 = n_del;
        cyc(20);
        check("redirect_delivers", 32'((n_del - d0) >= 4), 32'd1);

        // Redirect coinciding with a decode handshake and a response
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #2;
            if (id_valid && imem_rsp_valid) found = 1'b1;
        end
        check("found_hs_rsp_cycle", 32'(found), 32'd1);
        d0 = n_del;
        do_redirect(32'h200, 32'h200);
        check("hs_in_redirect_delivered", 32'(n_del - d0), 32'd1);
        @(negedge clk);
        check("id_valid_low_after_redirect2", 32'(id_valid), 32'd0);
        d0 = n_del;
        cyc(20);
        check("redirect2_delivers", 32'((n_del - d0) >= 4), 32'd1);

        // Memory backpressure holds the request address
        imem_req_ready = 1'b0;
        cyc(4);
        #1;
        held_addr = imem_req_addr;
        check("bp_valid_up", 32'(imem_req_valid), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #2;
            check("bp_valid_held", 32'(imem_req_valid), 32'd1);
            check("bp_addr_stable", imem_req_addr, held_addr);
        end
        imem_req_ready = 1'b1;

        // Address wrap past 0xFFFF_FFFC
        do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        d0 = n_del;
        cyc(20);
        check("wrap_delivers", 32'((n_del - d0) >= 4), 32'd1);

        // Back-to-back redirects with two stale requests in flight
        mem_hold = 1'b1;
        cyc(6);
        redirect_pc    = 32'h300;
        redirect_valid = 1'b1;
        cyc(1);
        redirect_pc = 32'h400;
        @(negedge clk);
        check("no_req_b2b", 32'(imem_req_valid), 32'd0);
        cyc(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        push_run(32'h400, 128);
        exp_addr = 32'h400;
        mem_hold = 1'b0;
        @(negedge clk);
        check("id_valid_low_after_b2b", 32'(id_valid), 32'd0);
        d0 = n_del;
        cyc(20);
        check("b2b_delivers", 32'((n_del - d0) >= 4), 32'd1);

        // Misaligned redirect target
`ifdef IFU_MISALIGN_CHECK_EN
        redirect_pc    = 32'h102;
        redirect_valid = 1'b1;
        cyc(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("misalign_set", 32'(misalign_err), 32'd1);
        a0 = n_acc;
        cyc(10);
        check("err_no_requests", 32'(n_acc - a0), 32'd0);
        check("err_id_valid_low", 32'(id_valid), 32'd0);
        check("misalign_sticky", 32'(misalign_err), 32'd1);
`else
        do_redirect(32'h102, 32'h100);
        @(negedge clk);
        check("id_valid_low_after_misalign", 32'(id_valid), 32'd0);
        a0 = n_acc;
        d0 = n_del;
        cyc(20);
        check("misalign_resume_delivers", 32'((n_del - d0) >= 4), 32'd1);
        check("misalign_requests", 32'((n_acc - a0) >= 4), 32'd1);
        check("misalign_err_tied0", 32'(misalign_err), 32'd0);
`endif

        // Asynchronous reset mid-stream
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_id_valid", 32'(id_valid), 32'd0);
        check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_rst_id_pc", id_pc, 32'd0);
        check("async_rst_misalign", 32'(misalign_err), 32'd0);
        exp_q.delete();
        push_run(32'h0, 128);
        exp_addr = 32'h0;
        cyc(2);
        rst_n = 1'b1;
        d0 = n_del;
        cyc(20);
        check("post_reset_delivers", 32'((n_del - d0) >= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
